// File: rtl/gcd_pkg.sv
// Shared types and constants for the iterative GCD engine.
// Optional checker build: define GCD_ASSERT_EN.
package gcd_pkg;

  localparam int GCD_W = 16;

  // Operand field positions inside the packed in_data word
  localparam int A_MSB = 2 * GCD_W - 1;
  localparam int A_LSB = GCD_W;
  localparam int B_MSB = GCD_W - 1;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  function automatic logic [GCD_W-1:0] field_a(input logic [2*GCD_W-1:0] d);
    return d[A_MSB:A_LSB];
  endfunction

  function automatic logic [GCD_W-1:0] field_b(input logic [2*GCD_W-1:0] d);
    return d[B_MSB:B_LSB];
  endfunction

endpackage

// File: rtl/gcd_chk.sv
// Simulation-only checkers for the GCD engine; compiled only with GCD_ASSERT_EN.
// Shadow copies of the operands live here so the default build carries none.
`ifdef GCD_ASSERT_EN
module gcd_dp_chk
  import gcd_pkg::*;
(
  input logic             clk,
  input logic             reset,
  input logic             load_i,
  input logic             step_i,
  input logic [GCD_W-1:0] a_i,
  input logic [GCD_W-1:0] b_i,
  input logic [GCD_W-1:0] x_i,
  input logic [GCD_W-1:0] y_i,
  input logic [GCD_W-1:0] result_i
);

  logic [GCD_W-1:0] a_sh_q, b_sh_q, x_prev_q, y_prev_q;
  logic             stepped_q, done_q;

  // Shadow operands and previous-cycle x/y history.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q    <= {GCD_W{1'b0}};
      b_sh_q    <= {GCD_W{1'b0}};
      x_prev_q  <= {GCD_W{1'b0}};
      y_prev_q  <= {GCD_W{1'b0}};
      stepped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (load_i) begin
        a_sh_q <= a_i;
        b_sh_q <= b_i;
      end
      x_prev_q  <= x_i;
      y_prev_q  <= y_i;
      stepped_q <= step_i;
      done_q    <= step_i && ((x_i == {GCD_W{1'b0}}) || (y_i == {GCD_W{1'b0}}));
    end
  end

  // x and y may not both grow, and the finished result must divide both operands.
  always @(posedge clk) begin
    if (!reset) begin
      if (stepped_q) begin
        assert (!((x_i > x_prev_q) && (y_i > y_prev_q)))
          else $error("gcd: x and y both increased in a step");
      end
      if (done_q) begin
        assert ((result_i == {GCD_W{1'b0}}) ?
                ((a_sh_q == {GCD_W{1'b0}}) && (b_sh_q == {GCD_W{1'b0}})) :
                (((a_sh_q % result_i) == {GCD_W{1'b0}}) && ((b_sh_q % result_i) == {GCD_W{1'b0}})))
          else $error("gcd: result %0d does not divide %0d and %0d", result_i, a_sh_q, b_sh_q);
      end
    end
  end

endmodule

module gcd_fsm_chk (
  input logic clk,
  input logic reset,
  input logic idle_i,
  input logic accept_i
);

  // Operands may only be taken while idle.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!accept_i || idle_i)
        else $error("gcd: operand accept outside IDLE");
    end
  end

endmodule
`endif

// File: rtl/gcd_datapath.sv
// x/y/result registers with compare, subtract and zero-detect for the GCD engine.
// Optional checker build: define GCD_ASSERT_EN.
module gcd_datapath
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [GCD_W-1:0] a_i,
  input  logic [GCD_W-1:0] b_i,
  output logic             x_zero_o,
  output logic             y_zero_o,
  output logic [GCD_W-1:0] result_o
);

  logic [GCD_W-1:0] x_q, x_d;
  logic [GCD_W-1:0] y_q, y_d;
  logic [GCD_W-1:0] result_q, result_d;
  logic             x_zero_s, y_zero_s, x_gt_y_s;

  assign x_zero_s = (x_q == {GCD_W{1'b0}});
  assign y_zero_s = (y_q == {GCD_W{1'b0}});
  assign x_gt_y_s = (x_q > y_q);

  // Next-state: load operands, or take one subtraction / finish step.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    if (load_i) begin
      x_d = a_i;
      y_d = b_i;
    end else if (step_i) begin
      if (y_zero_s) begin
        result_d = x_q;
      end else if (x_zero_s) begin
        result_d = y_q;
      end else if (x_gt_y_s) begin
        x_d = x_q - y_q;
      end else begin
        y_d = y_q - x_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= {GCD_W{1'b0}};
      y_q      <= {GCD_W{1'b0}};
      result_q <= {GCD_W{1'b0}};
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  assign x_zero_o = x_zero_s;
  assign y_zero_o = y_zero_s;
  assign result_o = result_q;

`ifdef GCD_ASSERT_EN
  gcd_dp_chk u_dp_chk (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_i),
    .step_i   (step_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .x_i      (x_q),
    .y_i      (y_q),
    .result_i (result_q)
  );
`endif

endmodule

// File: rtl/gcd.sv
// Iterative subtractive GCD engine: ready/valid operand input, level-valid result output.
// Optional checker build: define GCD_ASSERT_EN.
module gcd
  import gcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2*GCD_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [GCD_W-1:0]   out_data
);

  gcd_state_t       state_q;
  logic             in_ready_q, out_valid_q;
  logic             load_s, step_s;
  logic             x_zero_s, y_zero_s;
  logic [GCD_W-1:0] result_s;

  // Datapath controls decoded from the current state.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_q)
      IDLE:    load_s = in_valid;
      BUSY:    step_s = 1'b1;
      DONE:    load_s = 1'b0;
      default: load_s = 1'b0;
    endcase
  end

  // Control FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          if (x_zero_s || y_zero_s) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // A producer still holding in_valid must release it before the next job
          if (!in_valid) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  gcd_datapath u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_s),
    .step_i   (step_s),
    .a_i      (field_a(in_data)),
    .b_i      (field_b(in_data)),
    .x_zero_o (x_zero_s),
    .y_zero_o (y_zero_s),
    .result_o (result_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = result_s;

`ifdef GCD_ASSERT_EN
  gcd_fsm_chk u_fsm_chk (
    .clk      (clk),
    .reset    (reset),
    .idle_i   (state_q == IDLE),
    .accept_i (load_s)
  );
`endif

endmodule

// File: tb/tb_gcd.sv
// Directed and seeded-random bench for gcd; latencies count edges from the accept edge inclusive.
module tb_gcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gcd dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Euclid by remainder, independent of the subtractive hardware
  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 16'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int exp_edges, input int limit, input int hold);
    int edges;
    bit ready_seen;
    in_data  = {a, b};
    in_valid = 1'b1;
    tick;
    edges = 1;
    ready_seen = 1'b0;
    while (!out_valid && edges < limit) begin
      if (in_ready) ready_seen = 1'b1;
      tick;
      edges++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (exp_edges > 0) check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_ready_busy"}, {31'd0, ready_seen}, 32'd0);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, gcd_ref(a, b)});
    if (hold > 0) begin
      repeat (hold) tick;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_data"}, {16'd0, out_data}, {16'd0, gcd_ref(a, b)});
    end
    in_valid = 1'b0;
    tick;
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] g, m, n;

    // Reset for two edges
    tick;
    tick;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    reset = 1'b0;

    // (48,32): x=16, y=16, y=0, done -> valid 4 edges past accept
    run_job("p48_32", 16'd48, 16'd32, 5, 20, 3);

    run_job("p0_7", 16'd0, 16'd7, 2, 20, 0);
    run_job("p7_0", 16'd7, 16'd0, 2, 20, 0);
    run_job("p0_0", 16'd0, 16'd0, 2, 20, 0);

    // 65534 subtractions of 1, one x==y step, then the finish step
    run_job("p65535_1", 16'd65535, 16'd1, 65537, 70000, 0);

    // x=7, y=7, y=0, done
    run_job("p21_14", 16'd21, 16'd14, 5, 20, 0);

    // Abort a long job with reset
    in_data  = {16'd1000, 16'd3};
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    check("abort_busy_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_valid", {31'd0, out_valid}, 32'd0);

    // (12,18): y=6, x=6, y=0, done
    run_job("p12_18", 16'd12, 16'd18, 5, 20, 0);

    // Random pairs sharing a random factor keep runtimes short
    for (int k = 0; k < 8; k++) begin
      g = 16'($urandom_range(1, 255));
      m = 16'($urandom_range(1, 255));
      n = 16'($urandom_range(1, 255));
      run_job("rand", 16'(g * m), 16'(g * n), 0, 2000, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
